linear_layer_scheduler: RTL
===========================

# linear_layer_scheduler

Sequencer for the fixed-point linear-layer datapath: walks every output neuron of a layer through every N-wide input tile, drives weight/feature/bias memory addresses and tile tags into the multiplier datapath, and tracks in-flight results so each neuron's quantised output is presented with a valid/ready handshake. Sits between the layer-level control (start/done) and the multiplier datapath plus its weight, feature and bias memories; back-pressure is applied by freezing the datapath clock enable.

## Interface
- NUM_OUT, 64, output neurons per layer (≥1)
- IN_TILES, 4, N-element input tiles per neuron (≥1)
- PIPE_LATENCY, 6, enabled cycles from issuing a tile to that tile's result at the datapath output (≥2)
- W_ADDR_W, $clog2(NUM_OUT*IN_TILES), weight-memory address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a layer; sampled only in IDLE
- out_ready  in  1  downstream accepts the current result
- dp_ce  out  1  clock enable to datapath and memories
- w_addr  out  W_ADDR_W  weight row address = neuron*IN_TILES + tile
- f_tile  out  $clog2(IN_TILES) (min 1)  feature tile index
- b_addr  out  $clog2(NUM_OUT) (min 1)  bias address = current neuron
- issue_valid  out  1  a tile is issued this cycle
- issue_first  out  1  issued tile is tile 0 (accumulator clear)
- issue_last  out  1  issued tile is tile IN_TILES-1
- out_valid  out  1  datapath output holds a finished neuron
- out_neuron  out  $clog2(NUM_OUT) (min 1)  neuron index of that result
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last result is accepted

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all counters zero; start=1 → RUN. start in any other state ignored.
- RUN: each dp_ce=1 cycle issues one tile (issue_valid=1), tile counter increments, wraps at IN_TILES-1 and increments neuron counter. After issuing neuron NUM_OUT-1 tile IN_TILES-1 → DRAIN.
- DRAIN: no issues; waits until the in-flight tag pipe is empty and the final result is accepted → DONE.
- DONE: done=1 for one cycle, → IDLE.
- Tag pipe: PIPE_LATENCY-deep delay line carrying {issue_last, neuron}, advancing only when dp_ce=1. Tail entry with last=1 drives out_valid and out_neuron.
- Stall: dp_ce = !(out_valid && !out_ready). While low, counters, addresses, tag pipe and state hold; issue_valid forced 0.
- Handshake: result transferred when out_valid && out_ready; out_valid/out_neuron stable until then.
- Address arithmetic unsigned, no overflow by construction (W_ADDR_W sized to product).

## Timing
- Reset: state IDLE; every output 0 except dp_ce=1.
- start accepted at edge 0 → busy=1 and first issue in cycle 1.
- Unstalled: IN_TILES*NUM_OUT consecutive issue cycles; neuron k result at cycle (k+1)*IN_TILES + PIPE_LATENCY.
- done pulses the cycle after the final handshake; busy falls with done.
- out_ready low on a non-valid cycle has no effect (dp_ce stays 1).
- start coincident with done: ignored (state is DONE, not IDLE).
- rst mid-layer: immediate return to reset values; tag pipe cleared; no partial result emitted.

## Structure
- linear_ctrl_pkg: state enum, tag struct {last, neuron}, width localparams via $clog2 with min-1 guard.
- Sub-module tag_delay_line (parameterised width/depth, enable, async reset clearing all stages); scheduler FSM and counters in the top.

## Test plan
- NUM_OUT=2, IN_TILES=2, PIPE_LATENCY=6, out_ready=1, start at edge 0 → issues cycles 1–4 w_addr 0,1,2,3, first at 1,3, last at 2,4; out_valid cycles 8 (neuron 0) and 10 (neuron 1); done cycle 11.
- Same config, out_ready=0 cycles 8–10 → dp_ce=0 cycles 8–10, out_valid/out_neuron=0 held, neuron 1 result at cycle 13, done cycle 14.
- IN_TILES=1, NUM_OUT=3 → every issue has first=last=1; three back-to-back results neurons 0,1,2.
- start pulsed again during RUN and at done cycle → ignored; second start in IDLE begins new layer with w_addr 0.
- rst asserted at cycle 3 of a layer → outputs return to reset values same cycle, no out_valid afterward, new start runs full layer correctly.
- Random out_ready (50%), NUM_OUT=8, IN_TILES=3 → exactly 8 handshakes, neurons in order 0–7, one done pulse.

Source files
------------

// File: rtl/linear_layer_scheduler_pkg.sv
// Shared types and helpers for the linear-layer scheduler.
//   sched_state_e : scheduler FSM states
//   tag_t         : in-flight tile tag {last, neuron} carried alongside the datapath
//   clog2_min1    : $clog2 with a floor of 1 so single-entry ranges still get a bit
package linear_layer_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } sched_state_e;

  // Fixed-width neuron field so the tag can be a plain packed struct; layers
  // wider than this are rejected at elaboration in the scheduler.
  localparam int unsigned NeuronMaxW = 16;

  typedef struct packed {
    logic                  last;
    logic [NeuronMaxW-1:0] neuron;
  } tag_t;

  localparam int unsigned TagW = $bits(tag_t);

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/linear_layer_scheduler_if.sv
// Scheduler-to-datapath bundle.
//   master : scheduler side (drives enables, addresses, tags, result handshake)
//   slave  : layer control / datapath / consumer side
// Signals:
//   start, out_ready                        : into the scheduler
//   dp_ce, w_addr, f_tile, b_addr           : datapath clock enable and memory addresses
//   issue_valid, issue_first, issue_last    : per-tile issue strobes
//   out_valid, out_neuron                   : finished-neuron result handshake
//   busy, done                              : layer status
interface linear_layer_scheduler_if
  import linear_layer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OUT  = 64,
  parameter int unsigned IN_TILES = 4,
  parameter int unsigned W_ADDR_W = clog2_min1(NUM_OUT * IN_TILES)
) ();

  localparam int unsigned TileW   = clog2_min1(IN_TILES);
  localparam int unsigned NeuronW = clog2_min1(NUM_OUT);

  logic                start;
  logic                out_ready;
  logic                dp_ce;
  logic [W_ADDR_W-1:0] w_addr;
  logic [TileW-1:0]    f_tile;
  logic [NeuronW-1:0]  b_addr;
  logic                issue_valid;
  logic                issue_first;
  logic                issue_last;
  logic                out_valid;
  logic [NeuronW-1:0]  out_neuron;
  logic                busy;
  logic                done;

  modport master (
    input  start,
    input  out_ready,
    output dp_ce,
    output w_addr,
    output f_tile,
    output b_addr,
    output issue_valid,
    output issue_first,
    output issue_last,
    output out_valid,
    output out_neuron,
    output busy,
    output done
  );

  modport slave (
    output start,
    output out_ready,
    input  dp_ce,
    input  w_addr,
    input  f_tile,
    input  b_addr,
    input  issue_valid,
    input  issue_first,
    input  issue_last,
    input  out_valid,
    input  out_neuron,
    input  busy,
    input  done
  );

endinterface

// File: rtl/linear_layer_scheduler_tag_delay_line.sv
// Enabled shift register that mirrors the datapath pipeline for tile tags.
//   clk, rst : clock, asynchronous active-high reset (clears every stage)
//   en_i     : advance one stage (tied to the datapath clock enable)
//   d_i      : tag entering stage 0
//   q_o      : tag leaving the last stage, Depth enabled cycles after entry
module linear_layer_scheduler_tag_delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Depth-1:0][Width-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q <= {stage_q[Depth-2:0], d_i};
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/linear_layer_scheduler.sv
// Linear-layer sequencer: walks every output neuron through every input tile,
// drives weight/feature/bias addresses into the datapath and presents each
// neuron's finished result with a valid/ready handshake. Back-pressure freezes
// the whole datapath through dp_ce.
//   clk, rst : clock, asynchronous active-high reset
//   ctrl     : scheduler bundle (master side), see linear_layer_scheduler_if
module linear_layer_scheduler
  import linear_layer_scheduler_pkg::*;
#(
  parameter int unsigned NUM_OUT      = 64,
  parameter int unsigned IN_TILES     = 4,
  parameter int unsigned PIPE_LATENCY = 6,
  parameter int unsigned W_ADDR_W     = clog2_min1(NUM_OUT * IN_TILES)
) (
  input  logic                      clk,
  input  logic                      rst,
  linear_layer_scheduler_if.master  ctrl
);

  localparam int unsigned TileW   = clog2_min1(IN_TILES);
  localparam int unsigned NeuronW = clog2_min1(NUM_OUT);

  localparam logic [TileW-1:0]   LastTile   = TileW'(IN_TILES - 1);
  localparam logic [NeuronW-1:0] LastNeuron = NeuronW'(NUM_OUT - 1);

  if (NeuronW > NeuronMaxW || PIPE_LATENCY < 2) begin : g_bad_params
    $error("linear_layer_scheduler: NUM_OUT too large or PIPE_LATENCY < 2");
  end

  sched_state_e        state_q;
  logic [TileW-1:0]    tile_q;
  logic [NeuronW-1:0]  neuron_q;
  logic [W_ADDR_W-1:0] w_addr_q;

  logic               dp_ce;
  logic               issue;
  logic               tile_last;
  logic               neuron_last;
  logic               out_valid;
  logic [NeuronW-1:0] out_neuron;
  logic               handshake;
  logic               final_xfer;
  tag_t               tag_in;
  tag_t               tag_tail;

  // Only the tail tag can stall the pipe: a result waiting on out_ready.
  assign out_valid  = tag_tail.last;
  assign out_neuron = tag_tail.neuron[NeuronW-1:0];
  assign dp_ce      = !(out_valid && !ctrl.out_ready);
  assign issue      = (state_q == StRun) && dp_ce;

  assign tile_last   = (tile_q == LastTile);
  assign neuron_last = (neuron_q == LastNeuron);
  assign handshake   = out_valid && ctrl.out_ready;
  assign final_xfer  = handshake && (out_neuron == LastNeuron);

  // Non-issue cycles push an empty tag (last=0) so bubbles never raise out_valid.
  always_comb begin
    tag_in        = '0;
    tag_in.last   = issue && tile_last;
    tag_in.neuron = NeuronMaxW'(neuron_q);
  end

  linear_layer_scheduler_tag_delay_line #(
    .Width (TagW),
    .Depth (PIPE_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .en_i (dp_ce),
    .d_i  (tag_in),
    .q_o  (tag_tail)
  );

  // Upper neuron bits of the tail tag are always zero for this layer size.
  logic unused_tag_bits;
  assign unused_tag_bits = ^(tag_tail.neuron >> NeuronW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      tile_q   <= '0;
      neuron_q <= '0;
      w_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tile_q   <= '0;
          neuron_q <= '0;
          w_addr_q <= '0;
          if (ctrl.start) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          if (dp_ce) begin
            if (tile_last) begin
              tile_q <= '0;
              if (neuron_last) begin
                // Final tile issued: park counters at zero for the next layer.
                neuron_q <= '0;
                w_addr_q <= '0;
                state_q  <= StDrain;
              end else begin
                neuron_q <= neuron_q + NeuronW'(1);
                w_addr_q <= w_addr_q + W_ADDR_W'(1);
              end
            end else begin
              tile_q   <= tile_q + TileW'(1);
              w_addr_q <= w_addr_q + W_ADDR_W'(1);
            end
          end
        end
        StDrain: begin
          // Last neuron's tag is the final live entry; its transfer empties the pipe.
          if (final_xfer) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ctrl.dp_ce       = dp_ce;
  assign ctrl.issue_valid = issue;
  assign ctrl.issue_first = issue && (tile_q == '0);
  assign ctrl.issue_last  = issue && tile_last;
  assign ctrl.w_addr      = w_addr_q;
  assign ctrl.f_tile      = tile_q;
  assign ctrl.b_addr      = neuron_q;
  assign ctrl.out_valid   = out_valid;
  assign ctrl.out_neuron  = out_neuron;
  assign ctrl.busy        = (state_q != StIdle);
  assign ctrl.done        = (state_q == StDone);

endmodule
